// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: shares the data memory between core and DMA, builds byte lanes,
// waits out the read latency and returns extended load data.
module dmem_access_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [1:0]      core_size_i,
  input  logic            core_unsigned_i,
  input  logic [AW-1:0]   core_addr_i,
  input  logic [DW-1:0]   core_wdata_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic [DW-1:0]   core_rdata_o,
  output logic            core_err_o,
  input  logic            dma_req_i,
  input  logic            dma_we_i,
  input  logic [AW-1:0]   dma_addr_i,
  input  logic [DW-1:0]   dma_wdata_i,
  output logic            dma_gnt_o,
  output logic            dma_rvalid_o,
  output logic [DW-1:0]   dma_rdata_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            busy_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0] lat_q, lat_d;
  logic own_q, own_d, uns_q, uns_d, we_q, we_d;
  logic [1:0] size_q, size_d, lo_q, lo_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [DW/8-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic core_rvalid_q, core_rvalid_d, dma_rvalid_q, dma_rvalid_d, core_err_q, core_err_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d, dma_rdata_q, dma_rdata_d, fmt;
  logic [15:0] sh;
  logic idle, dma_win, bad;
  assign idle       = state_q == IDLE;
  assign dma_win    = dma_req_i && (!core_req_i || starve_q == SW'(STARVE_MAX));
  assign core_gnt_o = idle && core_req_i && !dma_win;
  assign dma_gnt_o  = idle && dma_win;
  assign bad = core_size_i == 2'b11 || (core_size_i == 2'b01 && core_addr_i[0]) ||
               (core_size_i == 2'b10 && core_addr_i[1:0] != 2'b00);
  // halves are aligned, so one lane shift serves both byte and half loads
  assign sh  = 16'(mem_rdata_i >> {lo_q, 3'b000});
  assign fmt = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
               size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh} : mem_rdata_i;
  always_comb begin
    state_d = state_q;
    starve_d = starve_q;
    lat_d = lat_q;
    own_d = own_q;
    uns_d = uns_q;
    we_d = we_q;
    size_d = size_q;
    lo_d = lo_q;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    mem_be_d = '0;
    mem_addr_d = '0;
    mem_wdata_d = '0;
    core_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    core_err_d = 1'b0;
    core_rdata_d = core_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (dma_req_i && !dma_win) starve_d = starve_q + SW'(1);
        if (dma_gnt_o) begin
          starve_d = '0;
          own_d = 1'b1;
          we_d = dma_we_i;
          size_d = 2'b10;
          uns_d = 1'b0;
          lo_d = 2'b00;
          state_d = ISSUE;
          mem_en_d = 1'b1;
          mem_we_d = dma_we_i;
          mem_be_d = '1;
          mem_addr_d = dma_addr_i & ~AW'(3);
          mem_wdata_d = dma_wdata_i;
        end else if (core_gnt_o) begin
          own_d = 1'b0;
          we_d = core_we_i;
          size_d = core_size_i;
          uns_d = core_unsigned_i;
          lo_d = core_addr_i[1:0];
          state_d = bad ? ERR : ISSUE;
          core_err_d = bad;
          mem_en_d = !bad;
          mem_we_d = !bad && core_we_i;
          mem_be_d = bad ? '0 : core_size_i == 2'b00 ? 4'b0001 << core_addr_i[1:0] :
                     core_size_i == 2'b01 ? 4'b0011 << {core_addr_i[1], 1'b0} : 4'b1111;
          mem_addr_d = bad ? '0 : core_addr_i & ~AW'(3);
          mem_wdata_d = bad ? '0 : core_size_i == 2'b00 ? {4{core_wdata_i[7:0]}} :
                        core_size_i == 2'b01 ? {2{core_wdata_i[15:0]}} : core_wdata_i;
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        lat_d = 3'd1;
      end
      WAIT: begin
        if (lat_q == 3'(MEM_LAT)) begin
          state_d = RESP;
          core_rvalid_d = !own_q;
          dma_rvalid_d = own_q;
          core_rdata_d = own_q ? core_rdata_q : fmt;
          dma_rdata_d = own_q ? mem_rdata_i : dma_rdata_q;
        end else lat_d = lat_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      starve_q <= '0;
      lat_q <= '0;
      own_q <= 1'b0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      size_q <= '0;
      lo_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_be_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      core_err_q <= 1'b0;
      core_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      lat_q <= lat_d;
      own_q <= own_d;
      uns_q <= uns_d;
      we_q <= we_d;
      size_q <= size_d;
      lo_q <= lo_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_be_q <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rvalid_q <= core_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      core_err_q <= core_err_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign core_err_o    = core_err_q;
  assign dma_rvalid_o  = dma_rvalid_q;
  assign dma_rdata_o   = dma_rdata_q;
  assign busy_o        = !idle;
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb_dmem_access_arbiter: scoreboard bench for the data-memory arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_dmem_access_arbiter;
  localparam int LAT = 1;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} mreq_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic core_req, core_we, core_uns, core_gnt, core_rvalid, core_err;
  logic [1:0] core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic mem_en, mem_we, busy;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic c3_req, c3_gnt, c3_rvalid, c3_err, d3_gnt, d3_rvalid, m3_en, m3_we, busy3;
  logic [31:0] c3_addr, c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata, p0, p1;
  logic [3:0] m3_be;
  mreq_t exp_mem[$];
  logic [31:0] exp_rd[$];
  int errors = 0, checks = 0;

  dmem_access_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size), .core_unsigned_i(core_uns),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy));

  dmem_access_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .core_req_i(c3_req), .core_we_i(1'b0), .core_size_i(2'b10), .core_unsigned_i(1'b0),
    .core_addr_i(c3_addr), .core_wdata_i(32'h0), .core_gnt_o(c3_gnt),
    .core_rvalid_o(c3_rvalid), .core_rdata_o(c3_rdata), .core_err_o(c3_err),
    .dma_req_i(1'b0), .dma_we_i(1'b0), .dma_addr_i(32'h0), .dma_wdata_i(32'h0),
    .dma_gnt_o(d3_gnt), .dma_rvalid_o(d3_rvalid), .dma_rdata_o(d3_rdata),
    .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_be_o(m3_be), .mem_addr_o(m3_addr),
    .mem_wdata_o(m3_wdata), .mem_rdata_i(m3_rdata), .busy_o(busy3));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a[7:2] == 6'd4 ? 32'h8001_7FFF : {24'hC0DE00, a[7:0]};
  endfunction

  // read data is only valid in the exact latency cycle; other cycles carry a poison word
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    p0 <= (m3_en && !m3_we) ? mem_word(m3_addr) : 32'hDEAD_BEEF;
    p1 <= p0;
    m3_rdata <= p1;
  end

  task automatic op(input bit dma, input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wd, input bit exp_err,
                    input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd, input string nm);
    mreq_t m;
    logic [31:0] e, rd;
    int waited, nerr;
    bit rv, orv;
    if (!exp_err) exp_mem.push_back('{we, ebe, {addr[31:2], 2'b00}, ewd});
    if (!exp_err && !we) exp_rd.push_back(erd);
    @(posedge clk); #1;
    if (dma) begin
      dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end else begin
      core_req = 1; core_we = we; core_size = size; core_uns = uns; core_addr = addr; core_wdata = wd;
    end
    waited = 0;
    @(negedge clk);
    while (!(dma ? dma_gnt : core_gnt) && waited < 20) begin @(negedge clk); waited++; end
    checks++;
    if (!(dma ? dma_gnt : core_gnt)) begin errors++; $display("FAIL %s gnt: got 0 want 1 within 20 cycles", nm); end
    @(posedge clk); #1;
    core_req = 0; dma_req = 0;
    nerr = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      rv = dma ? dma_rvalid : core_rvalid;
      orv = dma ? core_rvalid : dma_rvalid;
      rd = dma ? dma_rdata : core_rdata;
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", nm, busy); end
      end
      if (core_err) begin
        nerr++; checks++;
        if (k != 1) begin errors++; $display("FAIL %s err_timing: got cycle %0d want 1", nm, k); end
      end
      if (mem_en) begin
        checks++;
        if (exp_mem.size() == 0) begin errors++; $display("FAIL %s mem_en: got unexpected access addr=%h", nm, mem_addr); end
        else begin
          m = exp_mem.pop_front();
          if (k != 1 || {mem_we, mem_be, mem_addr} !== {m.we, m.be, m.addr} || (m.we && mem_wdata !== m.wdata)) begin
            errors++;
            $display("FAIL %s mem: got cyc=%0d we=%b be=%b addr=%h wd=%h want cyc=1 we=%b be=%b addr=%h wd=%h",
                     nm, k, mem_we, mem_be, mem_addr, mem_wdata, m.we, m.be, m.addr, m.wdata);
          end
        end
      end else begin
        checks++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
          errors++; $display("FAIL %s mem_idle: got we=%b be=%b addr=%h wd=%h want all 0", nm, mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (rv) begin
        checks++;
        if (exp_rd.size() == 0) begin errors++; $display("FAIL %s rvalid: got unexpected pulse data=%h", nm, rd); end
        else begin
          e = exp_rd.pop_front();
          if (rd !== e || k != LAT + 2) begin
            errors++; $display("FAIL %s rdata: got %h at cycle %0d want %h at cycle %0d", nm, rd, k, e, LAT + 2);
          end
        end
      end
      if (orv) begin checks++; errors++; $display("FAIL %s owner: got rvalid on other port want none", nm); end
    end
    checks++;
    if (nerr != int'(exp_err)) begin errors++; $display("FAIL %s err_count: got %0d want %0d", nm, nerr, exp_err); end
    checks++;
    if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
      errors++; $display("FAIL %s missing: got %0d mem/%0d rd outstanding want 0", nm, exp_mem.size(), exp_rd.size());
    end
    exp_mem.delete(); exp_rd.delete();
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_gnt, core_rvalid, core_rdata, core_err, dma_gnt, dma_rvalid, dma_rdata,
         mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy} !== '0) begin
      errors++; $display("FAIL reset_main: got busy=%b mem_en=%b rdata=%h want all 0", busy, mem_en, core_rdata);
    end
    checks++;
    if ({c3_gnt, c3_rvalid, c3_rdata, c3_err, d3_gnt, d3_rvalid, d3_rdata,
         m3_en, m3_we, m3_be, m3_addr, m3_wdata, busy3} !== '0) begin
      errors++; $display("FAIL reset_lat3: got busy=%b mem_en=%b want all 0", busy3, m3_en);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_core_loads;
    op(0, 0, 2'b10, 0, 32'h10, 0, 0, 4'b1111, 0, 32'h8001_7FFF, "lw_10");
    op(0, 0, 2'b00, 0, 32'h13, 0, 0, 4'b1000, 0, 32'hFFFF_FF80, "lb_13");
    op(0, 0, 2'b01, 1, 32'h12, 0, 0, 4'b1100, 0, 32'h0000_8001, "lhu_12");
    op(0, 0, 2'b01, 0, 32'h12, 0, 0, 4'b1100, 0, 32'hFFFF_8001, "lh_12");
    op(0, 0, 2'b01, 0, 32'h10, 0, 0, 4'b0011, 0, 32'h0000_7FFF, "lh_10");
    op(0, 0, 2'b00, 1, 32'h11, 0, 0, 4'b0010, 0, 32'h0000_007F, "lbu_11");
    op(0, 0, 2'b00, 0, 32'h10, 0, 0, 4'b0001, 0, 32'hFFFF_FFFF, "lb_10");
    op(0, 0, 2'b00, 1, 32'h10, 0, 0, 4'b0001, 0, 32'h0000_00FF, "lbu_10");
  endtask

  task automatic test_core_stores;
    op(0, 1, 2'b00, 0, 32'h21, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5, 0, "sb_21");
    op(0, 1, 2'b00, 0, 32'h23, 32'hFFFF_FF5A, 0, 4'b1000, 32'h5A5A_5A5A, 0, "sb_23");
    op(0, 1, 2'b01, 0, 32'h22, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF, 0, "sh_22");
    op(0, 1, 2'b01, 0, 32'h20, 32'h1234_BEEF, 0, 4'b0011, 32'hBEEF_BEEF, 0, "sh_20");
    op(0, 1, 2'b10, 0, 32'h24, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D, 0, "sw_24");
  endtask

  task automatic test_misaligned;
    op(0, 0, 2'b10, 0, 32'h06, 0, 1, 0, 0, 0, "lw_06");
    op(0, 1, 2'b01, 0, 32'h03, 32'h1111, 1, 0, 0, 0, "sh_03");
    op(0, 0, 2'b11, 0, 32'h00, 0, 1, 0, 0, 0, "size_11");
    op(0, 0, 2'b01, 1, 32'h01, 0, 1, 0, 0, 0, "lhu_01");
  endtask

  task automatic test_dma;
    op(1, 0, 2'b10, 0, 32'h12, 0, 0, 4'b1111, 0, 32'h8001_7FFF, "dma_rd_12");
    op(1, 0, 2'b10, 0, 32'h24, 0, 0, 4'b1111, 0, 32'hC0DE_0024, "dma_rd_24");
    op(1, 1, 2'b10, 0, 32'h33, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, 0, "dma_wr_33");
  endtask

  task automatic test_starvation;
    logic [9:0] seq = '0;
    logic [9:0] want = 10'b10_0001_0000;
    int n = 0, cyc = 0;
    bit both = 0;
    @(posedge clk); #1;
    core_req = 1; core_we = 1; core_size = 2'b10; core_uns = 0; core_addr = 32'h40; core_wdata = 32'h1;
    dma_req = 1; dma_we = 1; dma_addr = 32'h44; dma_wdata = 32'h2;
    while (n < 10 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (core_gnt && dma_gnt) both = 1;
      if (core_gnt || dma_gnt) begin seq[n] = dma_gnt; n++; end
    end
    @(posedge clk); #1;
    core_req = 0; dma_req = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (n != 10) begin errors++; $display("FAIL starve_count: got %0d grants want 10 within 60 cycles", n); end
    checks++;
    if (seq !== want) begin errors++; $display("FAIL starve_order: got %b want %b (1=dma, bit0 first)", seq, want); end
    checks++;
    if (both) begin errors++; $display("FAIL starve_double: got both grants in one cycle want at most one"); end
  endtask

  task automatic test_reset_mid_wait;
    int w = 0, pulses = 0, k_rv = 0;
    logic [31:0] got = '0, e;
    @(posedge clk); #1 c3_req = 1; c3_addr = 32'h10;
    @(negedge clk);
    while (!c3_gnt && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!c3_gnt) begin errors++; $display("FAIL midwait_gnt: got 0 want 1 within 20 cycles"); end
    @(posedge clk); #1 c3_req = 0;
    @(negedge clk);
    checks++;
    if (m3_en !== 1'b1) begin errors++; $display("FAIL midwait_issue: got mem_en=%b want 1", m3_en); end
    @(negedge clk); #2 rst = 1; #1;
    checks++;
    if ({c3_gnt, c3_rvalid, c3_rdata, c3_err, m3_en, m3_we, m3_be, m3_addr, m3_wdata, busy3} !== '0) begin
      errors++; $display("FAIL midwait_async: got busy=%b mem_en=%b want all 0", busy3, m3_en);
    end
    @(posedge clk); #1 rst = 0;
    repeat (8) begin @(negedge clk); if (c3_rvalid) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midwait_stale: got %0d rvalid pulses want 0", pulses); end
    exp_rd.push_back(32'h8001_7FFF);
    @(posedge clk); #1 c3_req = 1; w = 0;
    @(negedge clk);
    while (!c3_gnt && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!c3_gnt) begin errors++; $display("FAIL after_rst_gnt: got 0 want 1 within 20 cycles"); end
    @(posedge clk); #1 c3_req = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (c3_rvalid) begin pulses++; k_rv = k; got = c3_rdata; end
    end
    e = exp_rd.size() != 0 ? exp_rd.pop_front() : 32'h0;
    checks++;
    if (pulses != 1 || k_rv != 5 || got !== e) begin
      errors++; $display("FAIL after_rst_read: got %0d pulses cyc=%0d data=%h want 1 pulse cyc=5 data=%h", pulses, k_rv, got, e);
    end
    exp_rd.delete();
  endtask

  initial begin
    core_req = 0; core_we = 0; core_size = 0; core_uns = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    c3_req = 0; c3_addr = 0;
    test_reset;
    test_core_loads;
    test_core_stores;
    test_misaligned;
    test_dma;
    test_starvation;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
